// File: rtl/wishbone_p_if.sv
// Wishbone B4 pipelined bus bundle: clock/reset plus master-to-slave
// request signals and slave-to-master response signals.
interface wishbone_p_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int GRANULARITY = 8
) (
    input logic clk_i,
    input logic rst_i
);
    localparam int SEL_WIDTH = DATA_WIDTH / GRANULARITY;

    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [ADDR_WIDTH-1:0] adr;
    logic [SEL_WIDTH-1:0]  sel;
    logic [DATA_WIDTH-1:0] dat_i;
    logic [DATA_WIDTH-1:0] dat_o;
    logic                  ack;
    logic                  stall;

    modport master (
        input  clk_i, rst_i,
        output cyc, stb, we, adr, sel, dat_i,
        input  dat_o, ack, stall
    );

    modport slave (
        input  clk_i, rst_i,
        input  cyc, stb, we, adr, sel, dat_i,
        output dat_o, ack, stall
    );
endinterface

// File: rtl/wb_p_ram_slave.sv
// Wishbone B4 pipelined RAM slave: one request per cycle, fixed-latency
// in-order acks, stall once MAX_OUTSTANDING requests are in flight.
module wb_p_ram_slave #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int GRANULARITY     = 8,
    parameter int DEPTH           = 1024,
    parameter int LATENCY         = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    wishbone_p_if.slave wb
);
    localparam int ADDR_LSB = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W    = $clog2(DEPTH);
    localparam int LANES    = DATA_WIDTH / GRANULARITY;
    localparam int CNT_W    = $clog2(MAX_OUTSTANDING) + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $fatal(1, "wb_p_ram_slave: DEPTH must be a power of two >= 2");
    end

    if ((MAX_OUTSTANDING < 1) || (MAX_OUTSTANDING > LATENCY)) begin : g_bad_outstanding
        $fatal(1, "wb_p_ram_slave: MAX_OUTSTANDING must lie in 1..LATENCY");
    end

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] data;
    } resp_t;

    logic [ADDR_WIDTH-1:0] adr;
    logic                  unused_adr;
    logic [IDX_W-1:0]      idx;
    logic                  accept;
    logic                  stall;
    logic                  ack;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    resp_t                 pipe_q [LATENCY];
    resp_t                 pipe_d [LATENCY];
    logic [DATA_WIDTH-1:0] mem_q  [DEPTH];

    // Upper address bits alias and byte-offset bits are don't-care.
    assign adr        = wb.adr;
    assign unused_adr = ^adr;
    assign idx        = adr[ADDR_LSB +: IDX_W];

    assign stall  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    assign accept = wb.cyc & wb.stb & ~stall;
    assign ack    = pipe_q[LATENCY-1].valid;

    assign wb.stall = stall;
    assign wb.ack   = ack;
    assign wb.dat_o = ack ? pipe_q[LATENCY-1].data : '0;

    always_comb begin
        // NOTE: every output of this block is assigned up front so no path leaves a latch.
        pipe_d[0] = '{valid: accept, data: (accept && !wb.we) ? mem_q[idx] : '0};
        for (int i = 1; i < LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        cnt_d = cnt_q + CNT_W'(accept) - CNT_W'(ack);

        // Dropping cyc aborts the cycle: every in-flight response is discarded.
        if (!wb.cyc) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_d[i] = '0;
            end
            cnt_d = '0;
        end
    end

    always_ff @(posedge wb.clk_i or posedge wb.rst_i) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (wb.rst_i) begin
            cnt_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            cnt_q  <= cnt_d;
            pipe_q <= pipe_d;
        end
    end

    // NOTE: the RAM array has no reset; its contents survive rst_i and it can map onto block RAM.
    always_ff @(posedge wb.clk_i) begin
        if (accept && wb.we) begin
            for (int k = 0; k < LANES; k++) begin
                if (wb.sel[k]) begin
                    mem_q[idx][k*GRANULARITY +: GRANULARITY] <= wb.dat_i[k*GRANULARITY +: GRANULARITY];
                end
            end
        end
    end
endmodule
